// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Multi-cycle data-memory responder for the cpu DM port. Accepts
//            one load/store per handshake, completes it LATENCY cycles later
//            and holds the pipeline with stall while busy.
//            Optional macro DM_WBUF_EN adds a one-entry posted write buffer.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [15:0] wrt_data,
    output logic [15:0] rd_data,
    output logic        rd_vld,
    output logic        stall
);

    localparam int         c_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam bit         c_LAT1  = (LATENCY == 1);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_BUSY  = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    // A latency below one has no meaningful completion cycle.
    generate
        if (LATENCY < 1) begin : g_bad_latency
            $fatal(1, "dmem_responder: LATENCY must be >= 1");
        end
    endgenerate

    logic [1:0]            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_op_wr;
    logic [DEPTH_LOG2-1:0] r_addr;
    logic [15:0]           r_data;
    logic [15:0]           r_mem [0:(1<<DEPTH_LOG2)-1];

    logic                  w_busy;
    logic                  w_accept;
    logic                  w_fsm_go;
    logic                  w_fsm_wr;
    logic                  w_fin_busy;
    logic                  w_fin;
    logic                  w_fin_wr;
    logic [DEPTH_LOG2-1:0] w_fin_addr;
    logic [15:0]           w_fin_data;
    logic [15:0]           w_rd_word;
    logic                  w_mem_we;
    logic [DEPTH_LOG2-1:0] w_mem_addr;
    logic [15:0]           w_mem_data;
    logic                  w_unused_addr_hi;

    // Upper address bits are intentionally ignored (address wraps).
    assign w_unused_addr_hi = ^addr[15:DEPTH_LOG2];

    assign w_busy     = (r_state == c_BUSY);
    assign w_accept   = rst_n & (re | we) & ~stall;
    assign w_fin_busy = w_busy && (r_cnt == c_CNT_W'(1));
    // With LATENCY==1 the operation completes on its own acceptance edge.
    assign w_fin      = w_fin_busy | (w_fsm_go & c_LAT1);
    assign w_fin_wr   = w_fin_busy ? r_op_wr : w_fsm_wr;
    assign w_fin_addr = w_fin_busy ? r_addr  : addr[DEPTH_LOG2-1:0];
    assign w_fin_data = w_fin_busy ? r_data  : wrt_data;

`ifdef DM_WBUF_EN
    localparam int c_WB_W = $clog2(LATENCY + 1);

    logic                  r_wb_vld;
    logic [c_WB_W-1:0]     r_wb_cnt;
    logic [DEPTH_LOG2-1:0] r_wb_addr;
    logic [15:0]           r_wb_data;
    logic                  w_wb_cap;
    logic                  w_wb_drain;
    logic                  w_unused_fin_data;

    // Writes bypass the FSM; only a write meeting a full buffer is held off.
    assign stall      = w_busy | (we & r_wb_vld);
    assign w_wb_cap   = w_accept & we;
    assign w_fsm_go   = w_accept & ~we;
    assign w_fsm_wr   = 1'b0;
    assign w_wb_drain = r_wb_vld && (r_wb_cnt == c_WB_W'(1));
    assign w_mem_we   = w_wb_drain;
    assign w_mem_addr = r_wb_addr;
    assign w_mem_data = r_wb_data;
    assign w_unused_fin_data = ^w_fin_data;
    // A pending buffered write is newer than the array, so it wins the read.
    assign w_rd_word  = (r_wb_vld && (r_wb_addr == w_fin_addr)) ? r_wb_data
                                                                 : r_mem[w_fin_addr];

    // Posted write buffer: capture, count down, drain into the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_vld  <= 1'b0;
            r_wb_cnt  <= '0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else if (w_wb_cap) begin
            r_wb_vld  <= 1'b1;
            r_wb_cnt  <= c_WB_W'(LATENCY);
            r_wb_addr <= addr[DEPTH_LOG2-1:0];
            r_wb_data <= wrt_data;
        end else if (w_wb_drain) begin
            r_wb_vld  <= 1'b0;
        end else if (r_wb_vld) begin
            r_wb_cnt  <= r_wb_cnt - c_WB_W'(1);
        end
    end
`else
    assign stall      = w_busy;
    assign w_fsm_go   = w_accept;
    // A write takes priority when both requests are raised together.
    assign w_fsm_wr   = we;
    assign w_mem_we   = w_fin & w_fin_wr;
    assign w_mem_addr = w_fin_addr;
    assign w_mem_data = w_fin_data;
    assign w_rd_word  = r_mem[w_fin_addr];
`endif

    // Request FSM: latch the operation and count down to its completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_op_wr <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                c_BUSY: begin
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_state <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                default: begin
                    if (w_fsm_go) begin
                        r_state <= c_LAT1 ? c_DONE : c_BUSY;
                        r_cnt   <= c_CNT_W'(LATENCY - 1);
                        r_op_wr <= w_fsm_wr;
                        r_addr  <= addr[DEPTH_LOG2-1:0];
                        r_data  <= wrt_data;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
            endcase
        end
    end

    // Read completion: update the result register and pulse rd_vld.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 16'h0000;
            rd_vld  <= 1'b0;
        end else begin
            rd_vld <= w_fin & ~w_fin_wr;
            if (w_fin && !w_fin_wr) begin
                rd_data <= w_rd_word;
            end
        end
    end

    // Data array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed self-checking bench for dmem_responder; one instance
//            with LATENCY=3 and one with LATENCY=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr, wd, rd_data;
    logic        re, we, rd_vld, stall;
    logic [15:0] addr1, wd1, rd_data1;
    logic        re1, we1, rd_vld1, stall1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .re(re), .we(we),
        .wrt_data(wd), .rd_data(rd_data), .rd_vld(rd_vld), .stall(stall)
    );

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .addr(addr1), .re(re1), .we(we1),
        .wrt_data(wd1), .rd_data(rd_data1), .rd_vld(rd_vld1), .stall(stall1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One request on the LATENCY=3 instance; returns one cycle after acceptance.
    task automatic req0(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        re = r; we = w; addr = a; wd = d;
        tick();
        re = 1'b0; we = 1'b0;
    endtask

    // Request plus wait until the DONE cycle of the LATENCY=3 instance.
    task automatic run0(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        req0(r, w, a, d);
        tick();
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        re = 0; we = 0; addr = 0; wd = 0;
        re1 = 0; we1 = 0; addr1 = 0; wd1 = 0;
        #2;
        n_total++; if (rd_data !== 16'h0000) $display("FAIL reset_rd_data act=%h exp=0000", rd_data); else n_pass++;
        n_total++; if (rd_vld !== 1'b0) $display("FAIL reset_rd_vld act=%b exp=0", rd_vld); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL reset_stall act=%b exp=0", stall); else n_pass++;
        n_total++; if (rd_data1 !== 16'h0000) $display("FAIL reset_rd_data1 act=%h exp=0000", rd_data1); else n_pass++;
        n_total++; if (stall1 !== 1'b0) $display("FAIL reset_stall1 act=%b exp=0", stall1); else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_busy;
        run0(1'b0, 1'b1, 16'h0005, 16'h1111);
        tick();
        run0(1'b1, 1'b0, 16'h0005, 16'h0000);
        n_total++; if (rd_data !== 16'h1111) $display("FAIL prior_read act=%h exp=1111", rd_data); else n_pass++;
        tick();
        req0(1'b0, 1'b1, 16'h0005, 16'hBEEF);
        n_total++; if (stall !== 1'b1) $display("FAIL midbusy_stall act=%b exp=1", stall); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if (rd_data !== 16'h0000) $display("FAIL abort_rd_data act=%h exp=0000", rd_data); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL abort_stall act=%b exp=0", stall); else n_pass++;
        n_total++; if (rd_vld !== 1'b0) $display("FAIL abort_rd_vld act=%b exp=0", rd_vld); else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        run0(1'b1, 1'b0, 16'h0005, 16'h0000);
        n_total++; if (rd_vld !== 1'b1) $display("FAIL abort_read_vld act=%b exp=1", rd_vld); else n_pass++;
        n_total++; if (rd_data !== 16'h1111) $display("FAIL abort_lost_write act=%h exp=1111", rd_data); else n_pass++;
        tick();
    endtask

    task automatic test_write_read;
        req0(1'b0, 1'b1, 16'h0010, 16'h1234);
        n_total++; if (stall !== 1'b1) $display("FAIL wr_stall_t1 act=%b exp=1", stall); else n_pass++;
        tick();
        n_total++; if (stall !== 1'b1) $display("FAIL wr_stall_t2 act=%b exp=1", stall); else n_pass++;
        tick();
        n_total++; if (stall !== 1'b0) $display("FAIL wr_stall_t3 act=%b exp=0", stall); else n_pass++;
        n_total++; if (rd_vld !== 1'b0) $display("FAIL wr_no_vld act=%b exp=0", rd_vld); else n_pass++;
        req0(1'b1, 1'b0, 16'h0010, 16'h0000);
        n_total++; if (rd_vld !== 1'b0) $display("FAIL rd_early_vld act=%b exp=0", rd_vld); else n_pass++;
        tick();
        tick();
        n_total++; if (rd_vld !== 1'b1) $display("FAIL raw_vld act=%b exp=1", rd_vld); else n_pass++;
        n_total++; if (rd_data !== 16'h1234) $display("FAIL raw_data act=%h exp=1234", rd_data); else n_pass++;
        tick();
        n_total++; if (rd_vld !== 1'b0) $display("FAIL vld_pulse act=%b exp=0", rd_vld); else n_pass++;
        n_total++; if (rd_data !== 16'h1234) $display("FAIL rd_hold act=%h exp=1234", rd_data); else n_pass++;
    endtask

    task automatic test_lat1;
        logic [15:0] v;
        logic        st_seen;
        st_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v = 16'h3C00 + 16'(i * 16'h0111);
            re1 = 1'b0; we1 = 1'b1; addr1 = 16'h0003; wd1 = v;
            st_seen = st_seen | stall1;
            tick();
            re1 = 1'b1; we1 = 1'b0;
            st_seen = st_seen | stall1;
            tick();
            re1 = 1'b0;
            n_total++; if (rd_vld1 !== 1'b1) $display("FAIL lat1_vld[%0d] act=%b exp=1", i, rd_vld1); else n_pass++;
            n_total++; if (rd_data1 !== v) $display("FAIL lat1_data[%0d] act=%h exp=%h", i, rd_data1, v); else n_pass++;
        end
        n_total++; if (st_seen !== 1'b0) $display("FAIL lat1_stall act=%b exp=0", st_seen); else n_pass++;
    endtask

    task automatic test_wrap;
        run0(1'b0, 1'b1, 16'h0405, 16'hAAAA);
        run0(1'b1, 1'b0, 16'h0005, 16'h0000);
        n_total++; if (rd_data !== 16'hAAAA) $display("FAIL wrap_data act=%h exp=aaaa", rd_data); else n_pass++;
        tick();
    endtask

    task automatic test_rw_same;
        logic seen;
        req0(1'b1, 1'b1, 16'h0020, 16'h5555);
        seen = rd_vld;
        tick(); seen = seen | rd_vld;
        tick(); seen = seen | rd_vld;
        tick(); seen = seen | rd_vld;
        n_total++; if (seen !== 1'b0) $display("FAIL rw_no_vld act=%b exp=0", seen); else n_pass++;
        run0(1'b1, 1'b0, 16'h0020, 16'h0000);
        n_total++; if (rd_data !== 16'h5555) $display("FAIL rw_write_won act=%h exp=5555", rd_data); else n_pass++;
        tick();
    endtask

`ifdef DM_WBUF_EN
    task automatic test_wbuf;
        re = 1'b0; we = 1'b1; addr = 16'h0030; wd = 16'h7777;
        #1;
        n_total++; if (stall !== 1'b0) $display("FAIL wb_no_stall act=%b exp=0", stall); else n_pass++;
        tick();
        we = 1'b0;
        run0(1'b1, 1'b0, 16'h0030, 16'h0000);
        n_total++; if (rd_data !== 16'h7777) $display("FAIL wb_fwd act=%h exp=7777", rd_data); else n_pass++;
        tick();
        req0(1'b0, 1'b1, 16'h0031, 16'h0001);
        we = 1'b1; addr = 16'h0032; wd = 16'h0002;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_total++; if (stall !== 1'b1) $display("FAIL wb_full_stall[%0d] act=%b exp=1", k, stall); else n_pass++;
            tick();
        end
        n_total++; if (stall !== 1'b0) $display("FAIL wb_drained act=%b exp=0", stall); else n_pass++;
        tick();
        we = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
`ifndef DM_WBUF_EN
        test_reset_mid_busy();
        test_write_read();
`endif
        test_lat1();
        test_wrap();
        test_rw_same();
`ifdef DM_WBUF_EN
        test_wbuf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
